// File: rtl/data_sram_confreg_resp.sv
// Data-side SRAM responder: word RAM plus a confreg window (LED, switch, timer, compare, irq).
// Read-first with fixed 1-cycle read latency; accepts an access every cycle, never back-pressures.
module data_sram_confreg_resp #(
  parameter int unsigned RAM_AW    = 14,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        timer_irq
);
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;
  localparam logic [13:0] OFF_LED   = 14'h0000;
  localparam logic [13:0] OFF_SW    = 14'h0001;
  localparam logic [13:0] OFF_TIMER = 14'h0002;
  localparam logic [13:0] OFF_CMP   = 14'h0003;
  localparam logic [13:0] OFF_IRQ   = 14'h0004;

  logic [31:0] mem [RAM_WORDS];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;
  logic [7:0]  sw_s1_q, sw_s2_q;

  logic              conf_hit;
  logic              wr_en;
  logic [13:0]       conf_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       wmask;
  logic [31:0]       conf_rd;
  logic              irq_set, irq_clr;
  logic              unused_addr_lsb;

  assign conf_hit        = (sram_addr[31:16] == CONF_BASE[31:16]);
  assign conf_off        = sram_addr[15:2];
  assign ram_idx         = sram_addr[RAM_AW+1:2];
  assign wr_en           = sram_en && (sram_we != 4'b0000);
  assign wmask           = {{8{sram_we[3]}}, {8{sram_we[2]}}, {8{sram_we[1]}}, {8{sram_we[0]}}};
  assign unused_addr_lsb = ^sram_addr[1:0];

  always_comb begin
    conf_rd = 32'h0;
    case (conf_off)
      OFF_LED:   conf_rd = {16'h0, led_q};
      OFF_SW:    conf_rd = {24'h0, sw_s2_q};
      OFF_TIMER: conf_rd = timer_q;
      OFF_CMP:   conf_rd = cmp_q;
      OFF_IRQ:   conf_rd = {31'h0, irq_q};
      default:   conf_rd = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    led_d   = led_q;
    timer_d = timer_q + 32'd1;
    cmp_d   = cmp_q;
    irq_clr = 1'b0;
    irq_set = (timer_q == cmp_q) && (cmp_q != 32'h0);
    if (sram_en) rdata_d = conf_hit ? conf_rd : mem[ram_idx];
    if (wr_en && conf_hit) begin
      case (conf_off)
        OFF_LED:   led_d   = (led_q & ~wmask[15:0]) | (sram_wdata[15:0] & wmask[15:0]);
        OFF_TIMER: timer_d = (timer_q & ~wmask) | (sram_wdata & wmask);
        OFF_CMP:   cmp_d   = (cmp_q & ~wmask) | (sram_wdata & wmask);
        OFF_IRQ:   irq_clr = sram_we[0] & sram_wdata[0];
        default:   ;
      endcase
    end
    // A match on the same edge as a clear keeps the interrupt pending.
    irq_d = irq_set | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'h0;
      led_q   <= 16'h0;
      timer_q <= 32'h0;
      cmp_q   <= 32'h0;
      irq_q   <= 1'b0;
      sw_s1_q <= 8'h0;
      sw_s2_q <= 8'h0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
      sw_s1_q <= switch;
      sw_s2_q <= sw_s1_q;
    end
  end

  // RAM contents survive reset; a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (resetn && wr_en && !conf_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  assign sram_rdata = rdata_q;
  assign led        = led_q;
  assign timer_irq  = irq_q;
endmodule
